// File: rtl/bsram_arb_pkg.sv
// Shared types and constants for the backup-RAM / HPS arbiter.
// Holds the arbiter FSM state enum and the BSRAM bus defaults.
package bsram_arb_pkg;

  localparam int BSRAM_AW = 20;
  localparam logic [7:0] BSRAM_NOMEM_Q = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE,
    ST_RELEASE
  } arb_state_e;

endpackage

// File: rtl/bsram_dirty_tracker.sv
// Sticky flag raised by mapper writes to backup RAM.
// A set in the same cycle as a clear wins over the clear.
module bsram_dirty_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic dirty
);

  // Set-priority sticky flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= 1'b0;
    end else if (set) begin
      dirty <= 1'b1;
    end else if (clr) begin
      dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/bsram_hps_arbiter.sv
// Shares the BSRAM port between the mapper (priority) and HPS.
// Optional dirty tracking is built when BSRAM_DIRTY_EN is defined.
module bsram_hps_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int AW       = BSRAM_AW,
  parameter int GUARD    = 2,
  parameter int WAIT_MAX = 4095
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  input  logic [AW-1:0] RAM_MASK,
  input  logic [AW-1:0] MAP_ADDR,
  input  logic [7:0]    MAP_D,
  input  logic          MAP_CE_N,
  input  logic          MAP_OE_N,
  input  logic          MAP_WE_N,
  output logic [7:0]    MAP_Q,
  input  logic          HPS_REQ,
  input  logic          HPS_WE,
  input  logic [AW-1:0] HPS_ADDR,
  input  logic [7:0]    HPS_D,
  output logic          HPS_ACK,
  output logic [7:0]    HPS_Q,
  output logic          HPS_STARVED,
  output logic [AW-1:0] BSRAM_ADDR,
  output logic [7:0]    BSRAM_D,
  output logic          BSRAM_CE_N,
  output logic          BSRAM_OE_N,
  output logic          BSRAM_WE_N,
  input  logic [7:0]    BSRAM_Q,
  output logic          DIRTY,
  input  logic          DIRTY_CLR
);

  localparam int QW = $clog2(GUARD + 1);
  localparam int WW = $clog2(WAIT_MAX + 2);
  localparam logic [QW-1:0] GUARD_Q  = QW'(GUARD);
  localparam logic [WW-1:0] WAIT_TOP = WW'(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  arb_state_e state;
  arb_state_e state_nxt;

  logic [QW-1:0] quiet_cnt;
  logic [WW-1:0] wait_cnt;
  logic [AW-1:0] lat_addr;
  logic [7:0]    lat_d;
  logic          lat_we;
  logic          held;
  logic          ack_q;
  logic          starved_q;
  logic [7:0]    rdata_q;

  logic no_mem;
  logic guard_ok;
  logic hps_drive;
  logic req_we;
  logic take;

  assign no_mem    = (RAM_MASK == '0);
  assign guard_ok  = MAP_CE_N && (quiet_cnt == GUARD_Q);
  assign hps_drive = MAP_CE_N && (state == ST_ISSUE);
  assign req_we    = held ? lat_we : HPS_WE;
  assign take      = (state == ST_IDLE) && (state_nxt != ST_IDLE);

  // State register.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the mapper always wins the ISSUE cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (HPS_REQ) begin
          if (no_mem) begin
            state_nxt = ST_DONE;
          end else if (guard_ok) begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (!MAP_CE_N) begin
          state_nxt = ST_IDLE;
        end else if (lat_we) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (!HPS_REQ) begin
          state_nxt = ST_IDLE;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // BSRAM bus mux; HPS drives only in an uncontested ISSUE cycle.
  always_comb begin
    BSRAM_ADDR = MAP_ADDR;
    BSRAM_D    = MAP_D;
    BSRAM_CE_N = MAP_CE_N;
    BSRAM_OE_N = MAP_OE_N;
    BSRAM_WE_N = MAP_WE_N;
    unique case (1'b1)
      hps_drive: begin
        BSRAM_ADDR = lat_addr;
        BSRAM_D    = lat_d;
        BSRAM_CE_N = 1'b0;
        BSRAM_OE_N = lat_we;
        BSRAM_WE_N = ~lat_we;
      end
      !hps_drive: begin
      end
      default: begin
      end
    endcase
  end

  // Guard/wait counters, request latch, ACK pulse and read data.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      quiet_cnt <= '0;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_d     <= '0;
      lat_we    <= 1'b0;
      held      <= 1'b0;
      ack_q     <= 1'b0;
      starved_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (!MAP_CE_N) begin
        quiet_cnt <= '0;
      end else if (quiet_cnt != GUARD_Q) begin
        quiet_cnt <= quiet_cnt + QW'(1);
      end

      ack_q <= (state == ST_DONE);

      if (take && !held) begin
        lat_addr <= HPS_ADDR & RAM_MASK;
        lat_d    <= HPS_D;
        lat_we   <= HPS_WE;
        held     <= 1'b1;
      end else if (state == ST_DONE) begin
        held     <= 1'b0;
      end

      if (state == ST_CAPTURE) begin
        rdata_q <= BSRAM_Q;
      end else if (take && state_nxt == ST_DONE && !req_we) begin
        rdata_q <= BSRAM_NOMEM_Q;
      end

      if (state == ST_DONE) begin
        wait_cnt  <= '0;
        starved_q <= 1'b0;
      end else if (HPS_REQ &&
                   (state == ST_IDLE || state == ST_ISSUE)) begin
        if (wait_cnt != WAIT_TOP) begin
          wait_cnt <= wait_cnt + WW'(1);
        end
        if (wait_cnt >= WAIT_LIM) begin
          starved_q <= 1'b1;
        end
      end
    end
  end

  assign MAP_Q       = BSRAM_Q;
  assign HPS_ACK     = ack_q;
  assign HPS_Q       = rdata_q;
  assign HPS_STARVED = starved_q;

`ifdef BSRAM_DIRTY_EN
  bsram_dirty_tracker u_dirty (
    .clk   (MCLK),
    .rst_n (RESET_N),
    .set   (!MAP_CE_N && !MAP_WE_N),
    .clr   (DIRTY_CLR),
    .dirty (DIRTY)
  );
`else
  logic unused_dirty_clr;
  assign unused_dirty_clr = DIRTY_CLR;
  assign DIRTY = 1'b0;
`endif

endmodule
